// File: rtl/vcve2_pkg.sv
// vcve2 shared types for the PMP CSR bank and the PMP access checker.
// Holds the CSR operation encoding, the PMP CSR addresses, the PMP config and
// mseccfg structures, and a few small helpers used by the CSR bank.
package vcve2_pkg;

  typedef enum logic [1:0] {
    PMP_CSR_READ  = 2'd0,
    PMP_CSR_WRITE = 2'd1,
    PMP_CSR_SET   = 2'd2,
    PMP_CSR_CLEAR = 2'd3
  } pmp_csr_op_e;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
  localparam logic [11:0] CSR_MSECCFG  = 12'h747;
  localparam logic [11:0] CSR_MSECCFGH = 12'h757;

  // Mask with the n lowest bits set (n <= 0 gives an all-zero mask).
  function automatic logic [31:0] low_ones(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Architectural byte image of a config entry; bits 6:5 always read as zero.
  function automatic logic [7:0] cfg_to_byte(input pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

endpackage

// File: rtl/vcve2_pmp_cfg_legalize.sv
// vcve2 PMP config byte legaliser (combinational).
// Turns a requested pmpcfg byte into the value that is actually stored,
// given the current entry value and the machine security state.
// Optional feature macro: VCVE2_PMP_MSECCFG_EN. When undefined, mml and rlb
// are treated as zero and the MML rejection path is absent.
module vcve2_pmp_cfg_legalize
  import vcve2_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0
) (
  input  pmp_cfg_t   old_cfg,
  input  logic [7:0] new_byte,
  input  logic       mml,
  input  logic       rlb,
  output pmp_cfg_t   stored_cfg
);

  localparam bit NoNa4 = (PMPGranularity >= 1);

  logic     mml_eff;
  logic     rlb_eff;
  logic     locked;
  logic     mml_reject;
  pmp_cfg_t cand;

  // Bits 6:5 are reserved and never stored.
  logic unused_reserved;
  assign unused_reserved = ^new_byte[6:5];

`ifdef VCVE2_PMP_MSECCFG_EN
  assign mml_eff = mml;
  assign rlb_eff = rlb;
`else
  logic unused_sec;
  assign unused_sec = mml ^ rlb;
  assign mml_eff    = 1'b0;
  assign rlb_eff    = 1'b0;
`endif

  // Decode the requested byte, apply WARL fixups and the lock/MML veto.
  always_comb begin
    cand.lock  = new_byte[7];
    cand.mode  = pmp_cfg_mode_e'(new_byte[4:3]);
    cand.exec  = new_byte[2];
    cand.write = new_byte[1];
    cand.read  = new_byte[0];
    // R=0/W=1 is reserved unless MML gives it a shared-region meaning.
    if (!mml_eff && !new_byte[0] && new_byte[1]) cand.write = 1'b0;
    // NA4 cannot be expressed once the granule exceeds 4 bytes.
    if (NoNa4 && (cand.mode == PMP_MODE_NA4)) cand.mode = PMP_MODE_OFF;
    locked     = old_cfg.lock & ~rlb_eff;
    mml_reject = mml_eff & ~rlb_eff & new_byte[7] &
                 (new_byte[2] | (~new_byte[0] & new_byte[1]));
    stored_cfg = (locked | mml_reject) ? old_cfg : cand;
  end

endmodule

// File: rtl/vcve2_pmp_csr.sv
// vcve2 PMP CSR bank: decodes pmpcfg0-3, pmpaddr0-15, mseccfg/mseccfgh,
// applies WARL/lock rules and drives the registered cfg/addr/mseccfg state
// consumed by the PMP access checker. Responses arrive one cycle after the
// request and carry the pre-write value.
// Optional feature macro: VCVE2_PMP_MSECCFG_EN (mseccfg implemented). When
// undefined, 0x747/0x757 are illegal and mseccfg is tied to zero.
module vcve2_pmp_csr
  import vcve2_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         csr_req_i,
  input  logic [11:0]  csr_addr_i,
  input  pmp_csr_op_e  csr_op_i,
  input  logic [31:0]  csr_wdata_i,
  output logic         csr_rvalid_o,
  output logic [31:0]  csr_rdata_o,
  output logic         csr_illegal_o,
  output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
  output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t csr_pmp_mseccfg_o
);

  // Read-side formatting of pmpaddr for coarse granules.
  localparam logic [31:0] NapotOnes =
      (PMPGranularity >= 2) ? low_ones(int'(PMPGranularity) - 1) : 32'h0;
  localparam logic [31:0] ClearMask = low_ones(int'(PMPGranularity));

  logic        mml_eff;
  logic        rlb_eff;
  logic        is_cfg;
  logic        is_addr;
  logic [1:0]  cfg_idx;
  logic [3:0]  addr_idx;
  logic [31:0] rdata_next;
  logic        illegal_next;
  logic [31:0] wval;
  logic        do_write;

  // Full 16-entry views; unimplemented entries read as zero.
  pmp_cfg_t    cfg_view  [16];
  logic [31:0] addr_view [16];

  assign is_cfg   = (csr_addr_i[11:2] == CSR_PMPCFG0[11:2]);
  assign is_addr  = (csr_addr_i[11:4] == CSR_PMPADDR0[11:4]);
  assign cfg_idx  = csr_addr_i[1:0];
  assign addr_idx = csr_addr_i[3:0];

`ifdef VCVE2_PMP_MSECCFG_EN
  logic         is_msec;
  logic         is_msech;
  logic         any_lock;
  logic         msec_we;
  pmp_mseccfg_t mseccfg_reg;

  assign is_msec  = (csr_addr_i == CSR_MSECCFG);
  assign is_msech = (csr_addr_i == CSR_MSECCFGH);
  assign msec_we  = do_write & is_msec;

  // rlb may only be raised while no entry carries an L bit.
  always_comb begin
    any_lock = 1'b0;
    for (int i = 0; i < 16; i++) any_lock = any_lock | cfg_view[i].lock;
  end

  // mml/mmwp are sticky once set; rlb follows the write only when permitted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mseccfg_reg <= '0;
    end else if (msec_we) begin
      mseccfg_reg.mml  <= mseccfg_reg.mml | wval[0];
      mseccfg_reg.mmwp <= mseccfg_reg.mmwp | wval[1];
      if (mseccfg_reg.rlb | ~any_lock) mseccfg_reg.rlb <= wval[2];
    end
  end

  assign csr_pmp_mseccfg_o = mseccfg_reg;
  assign mml_eff           = mseccfg_reg.mml;
  assign rlb_eff           = mseccfg_reg.rlb;
`else
  assign csr_pmp_mseccfg_o = '0;
  assign mml_eff           = 1'b0;
  assign rlb_eff           = 1'b0;
`endif

  // Read mux and address legality for the current request.
  always_comb begin
    rdata_next   = 32'h0;
    illegal_next = 1'b0;
    if (is_cfg) begin
      for (int b = 0; b < 4; b++) begin
        rdata_next[8*b +: 8] = cfg_to_byte(cfg_view[{cfg_idx, 2'(b)}]);
      end
    end else if (is_addr) begin
      rdata_next = addr_view[addr_idx];
`ifdef VCVE2_PMP_MSECCFG_EN
    end else if (is_msec) begin
      rdata_next = {29'h0, mseccfg_reg.rlb, mseccfg_reg.mmwp, mseccfg_reg.mml};
    end else if (is_msech) begin
      rdata_next = 32'h0;
`endif
    end else begin
      illegal_next = 1'b1;
    end
  end

  // Write operand: SET/CLEAR work on the value the requester observes.
  always_comb begin
    case (csr_op_i)
      PMP_CSR_WRITE: wval = csr_wdata_i;
      PMP_CSR_SET:   wval = rdata_next | csr_wdata_i;
      PMP_CSR_CLEAR: wval = rdata_next & ~csr_wdata_i;
      default:       wval = rdata_next;
    endcase
  end

  assign do_write = csr_req_i & (csr_op_i != PMP_CSR_READ) & ~illegal_next;

  for (genvar gi = 0; gi < 16; gi++) begin : g_entry
    if (gi < PMPNumRegions) begin : g_impl
      pmp_cfg_t    cfg_reg;
      pmp_cfg_t    cfg_next;
      logic [31:0] addr_reg;
      logic        cfg_we;
      logic        addr_we;
      logic        next_tor_lock;

      vcve2_pmp_cfg_legalize #(
        .PMPGranularity(PMPGranularity)
      ) u_legalize (
        .old_cfg   (cfg_reg),
        .new_byte  (wval[8*(gi%4) +: 8]),
        .mml       (mml_eff),
        .rlb       (rlb_eff),
        .stored_cfg(cfg_next)
      );

      // A locked TOR successor uses this address as its base.
      if (gi + 1 < PMPNumRegions) begin : g_next
        assign next_tor_lock = cfg_view[gi+1].lock & ~rlb_eff &
                               (cfg_view[gi+1].mode == PMP_MODE_TOR);
      end else begin : g_last
        assign next_tor_lock = 1'b0;
      end

      assign cfg_we  = do_write & is_cfg & (cfg_idx == 2'(gi / 4));
      assign addr_we = do_write & is_addr & (addr_idx == 4'(gi)) &
                       ~(cfg_reg.lock & ~rlb_eff) & ~next_tor_lock;

      // Entry state; lock vetoes for cfg are resolved inside the legaliser.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cfg_reg  <= '0;
          addr_reg <= '0;
        end else begin
          if (cfg_we)  cfg_reg  <= cfg_next;
          if (addr_we) addr_reg <= wval;
        end
      end

      assign cfg_view[gi]       = cfg_reg;
      assign addr_view[gi]      = (cfg_reg.mode == PMP_MODE_NAPOT) ?
                                  (addr_reg | NapotOnes) : (addr_reg & ~ClearMask);
      assign csr_pmp_cfg_o[gi]  = cfg_reg;
      assign csr_pmp_addr_o[gi] = {addr_reg, 2'b00};
    end else begin : g_unimpl
      assign cfg_view[gi]  = '0;
      assign addr_view[gi] = 32'h0;
    end
  end

  // Registered response, one cycle after the request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csr_rvalid_o  <= 1'b0;
      csr_rdata_o   <= 32'h0;
      csr_illegal_o <= 1'b0;
    end else begin
      csr_rvalid_o  <= csr_req_i;
      csr_rdata_o   <= csr_req_i ? rdata_next : 32'h0;
      csr_illegal_o <= csr_req_i & illegal_next;
    end
  end

endmodule
